// File: rtl/axi_regex_top_if.sv
// Host register bundle for the regex coprocessor.
// The host drives the command/data registers, and the engine drives status, read data and its FSM state.
interface axi_regex_top_if #(
    parameter int REG_WIDTH = 32
);
    // Commands are level-sensitive. There is no valid/ready pair:
    // a command is acted on in every cycle it is held on cmd_register.
    logic [REG_WIDTH-1:0] data_in_register;
    logic [REG_WIDTH-1:0] address_register;
    logic [REG_WIDTH-1:0] start_cc_pointer_register;
    logic [REG_WIDTH-1:0] cmd_register;
    logic [REG_WIDTH-1:0] status_register;
    logic [REG_WIDTH-1:0] data_o_register;
    logic [2:0]           engine_state;

    modport master (
        output data_in_register, address_register, start_cc_pointer_register, cmd_register,
        input  status_register, data_o_register, engine_state
    );

    modport slave (
        input  data_in_register, address_register, start_cc_pointer_register, cmd_register,
        output status_register, data_o_register, engine_state
    );
endinterface

// File: rtl/axi_regex_top.sv
// Backtracking regex VM over a shared 16-bit word memory, driven by host registers.
// Optional REGEX_TIMEOUT_EN adds a run-cycle limit of MAX_CYCLES that forces REJECTED.
module axi_regex_top #(
    parameter int REG_WIDTH   = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int STACK_DEPTH = 16,
    parameter int MAX_CYCLES  = 4096
) (
    input  logic           clk,
    input  logic           reset,
    axi_regex_top_if.slave bus
);
    localparam int MEM_DEPTH = 1 << MEM_ADDR_W;
    localparam int CC_W      = MEM_ADDR_W + 1;
    localparam int SP_W      = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W     = $clog2(STACK_DEPTH);

    localparam logic [REG_WIDTH-1:0] CMD_WRITE = 1;
    localparam logic [REG_WIDTH-1:0] CMD_READ  = 2;
    localparam logic [REG_WIDTH-1:0] CMD_START = 3;

    localparam logic [7:0] OP_ACCEPT = 8'h00;
    localparam logic [7:0] OP_MATCH  = 8'h01;
    localparam logic [7:0] OP_JMP    = 8'h02;
    localparam logic [7:0] OP_SPLIT  = 8'h03;
    localparam logic [7:0] OP_ANY    = 8'h04;

    localparam logic [MEM_ADDR_W-1:0] PC_ONE = 1;
    localparam logic [CC_W-1:0]       CC_ONE = 1;
    localparam logic [SP_W-1:0]       SP_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ACCEPTED,
        S_REJECTED
    } state_t;

    state_t state, state_n;

    logic [15:0]           mem [0:MEM_DEPTH-1];
    logic [MEM_ADDR_W-1:0] stk_pc [0:STACK_DEPTH-1];
    logic [CC_W-1:0]       stk_cc [0:STACK_DEPTH-1];

    logic [MEM_ADDR_W-1:0] pc, pc_n;
    logic [CC_W-1:0]       cc, cc_n;
    logic [SP_W-1:0]       sp, sp_n;
    logic [15:0]           instr_q;
    logic [7:0]            char_q;
    logic [15:0]           rd_q;
    logic                  do_push;
    logic                  fail;

    logic                  running;
    logic                  cmd_write, cmd_read, cmd_start;
    logic [MEM_ADDR_W-1:0] addr, addr_p1, start_word;
    logic [7:0]            op, arg;
    logic [IDX_W-1:0]      push_idx, top_idx;
    logic                  stack_full;
    logic                  unused_bits;

    assign running    = (state == S_FETCH) || (state == S_EXEC);
    assign cmd_write  = (bus.cmd_register == CMD_WRITE);
    assign cmd_read   = (bus.cmd_register == CMD_READ);
    assign cmd_start  = (bus.cmd_register == CMD_START);
    assign addr       = bus.address_register[MEM_ADDR_W-1:0];
    assign addr_p1    = addr + PC_ONE;
    assign start_word = bus.start_cc_pointer_register[MEM_ADDR_W-1:0];
    assign op         = instr_q[15:8];
    assign arg        = instr_q[7:0];
    assign push_idx   = sp[IDX_W-1:0];
    assign top_idx    = sp[IDX_W-1:0] - 1'b1;
    assign stack_full = (sp == SP_W'(STACK_DEPTH));

    assign unused_bits = ^{bus.address_register[REG_WIDTH-1:MEM_ADDR_W],
                           bus.start_cc_pointer_register[REG_WIDTH-1:MEM_ADDR_W],
                           32'(MAX_CYCLES)};

`ifdef REGEX_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (!running && cmd_start) begin
            cyc_cnt <= '0;
        end else if (running) begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
        end
    end
`endif

    // Memory is deliberately not reset so that a program survives a host reset.
    always_ff @(posedge clk) begin
        if (cmd_write && !running) begin
            mem[addr]    <= bus.data_in_register[15:0];
            mem[addr_p1] <= bus.data_in_register[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            stk_pc[push_idx] <= MEM_ADDR_W'(arg);
            stk_cc[push_idx] <= cc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            cc      <= '0;
            sp      <= '0;
            instr_q <= '0;
            char_q  <= '0;
            rd_q    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cc    <= cc_n;
            sp    <= sp_n;
            if (cmd_read && !running) begin
                rd_q <= mem[addr];
            end
            // Second read port fetches the character at byte cc alongside the instruction.
            if (state == S_FETCH) begin
                instr_q <= mem[pc];
                char_q  <= cc[0] ? mem[cc[CC_W-1:1]][15:8] : mem[cc[CC_W-1:1]][7:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cc_n    = cc;
        sp_n    = sp;
        do_push = 1'b0;
        fail    = 1'b0;
        case (state)
            S_IDLE, S_ACCEPTED, S_REJECTED: begin
                if (cmd_start) begin
                    state_n = S_FETCH;
                    pc_n    = '0;
                    cc_n    = {start_word, 1'b0};
                    sp_n    = '0;
                end
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_FETCH;
                case (op)
                    OP_ACCEPT: begin
                        if (char_q == 8'h00) state_n = S_ACCEPTED;
                        else                 fail    = 1'b1;
                    end
                    OP_MATCH: begin
                        if (char_q == arg && char_q != 8'h00) begin
                            cc_n = cc + CC_ONE;
                            pc_n = pc + PC_ONE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                    OP_JMP: pc_n = MEM_ADDR_W'(arg);
                    OP_SPLIT: begin
                        if (stack_full) begin
                            state_n = S_REJECTED;
                        end else begin
                            do_push = 1'b1;
                            sp_n    = sp + SP_ONE;
                            pc_n    = pc + PC_ONE;
                        end
                    end
                    OP_ANY: begin
                        if (char_q != 8'h00) begin
                            cc_n = cc + CC_ONE;
                            pc_n = pc + PC_ONE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                    default: fail = 1'b1;
                endcase
                // A failed thread resumes from the most recent SPLIT alternative.
                if (fail) begin
                    if (sp != '0) begin
                        pc_n = stk_pc[top_idx];
                        cc_n = stk_cc[top_idx];
                        sp_n = sp - SP_ONE;
                    end else begin
                        state_n = S_REJECTED;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
`ifdef REGEX_TIMEOUT_EN
        if (running && cyc_cnt == CNT_W'(MAX_CYCLES - 1)) begin
            state_n = S_REJECTED;
        end
`endif
    end

    always_comb begin
        case (state)
            S_FETCH, S_EXEC: bus.status_register = REG_WIDTH'(1);
            S_ACCEPTED:      bus.status_register = REG_WIDTH'(2);
            S_REJECTED:      bus.status_register = REG_WIDTH'(3);
            default:         bus.status_register = '0;
        endcase
    end

    assign bus.data_o_register = {{(REG_WIDTH-16){1'b0}}, rd_q};
    assign bus.engine_state    = state;
endmodule

// File: tb/tb_axi_regex_top.sv
// Randomized self-checking bench for axi_regex_top against a regex-level reference model.
module tb_axi_regex_top;
    localparam logic [31:0] ST_IDLE = 0, ST_RUN = 1, ST_ACC = 2, ST_REJ = 3;
    localparam int MAX_CYCLES = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_regex_top_if bus ();
    axi_regex_top dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [15:0] mem_m [0:1023];
    logic [15:0] prog [0:31];
    logic [7:0]  str_b [0:31];
    logic [7:0]  pat [0:7];
    int          pat_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic [31:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] ptr);
        @(negedge clk);
        bus.cmd_register              = cmd;
        bus.address_register          = a;
        bus.data_in_register          = d;
        bus.start_cc_pointer_register = ptr;
        @(negedge clk);
        bus.cmd_register = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        drive_cmd(1, a, d, 0);
        mem_m[a % 1024]       = d[15:0];
        mem_m[(a + 1) % 1024] = d[31:16];
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        drive_cmd(2, a, 0, 0);
        d = bus.data_o_register;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic [31:0] st);
        int cyc = 0;
        while (cyc < budget && !(bus.status_register == ST_ACC || bus.status_register == ST_REJ)) begin
            @(negedge clk);
            cyc++;
        end
        st = bus.status_register;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i += 2) do_write(i, {prog[i+1], prog[i]});
    endtask

    task automatic load_str(input logic [31:0] ptr, input int n);
        for (int i = n; i < 32; i++) str_b[i] = 8'h00;
        for (int k = 0; 4 * k < n + 1; k++)
            do_write(ptr + 2 * k, {str_b[4*k+3], str_b[4*k+2], str_b[4*k+1], str_b[4*k]});
    endtask

    task automatic run_case(input string tag, input logic [31:0] ptr, input logic [31:0] exp_st);
        logic [31:0] st;
        drive_cmd(3, 0, 0, ptr);
        check_eq({tag, "_running"}, bus.status_register, ST_RUN);
        wait_done(3000, st);
        check_eq({tag, "_result"}, st, exp_st);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    endtask

    task automatic set_abc_prog();
        clear_prog();
        prog[0] = 16'h0161; prog[1] = 16'h0307; prog[2] = 16'h0305; prog[3] = 16'h0162;
        prog[4] = 16'h0201; prog[5] = 16'h0163; prog[6] = 16'h0201; prog[7] = 16'h0000;
    endtask

    // a(b|c)*: a leading 'a', then only 'b' or 'c' up to the terminator.
    function automatic logic [31:0] model_abc(input int n);
        if (n < 1 || str_b[0] != "a") return ST_REJ;
        for (int i = 1; i < n; i++)
            if (str_b[i] != "b" && str_b[i] != "c") return ST_REJ;
        return ST_ACC;
    endfunction

    // Anchored literal/wildcard pattern (pat entry 0 = any char) consuming the whole string.
    function automatic logic [31:0] model_lin(input int n);
        if (n != pat_n) return ST_REJ;
        for (int i = 0; i < n; i++)
            if (pat[i] != 8'h00 && pat[i] != str_b[i]) return ST_REJ;
        return ST_ACC;
    endfunction

    initial begin
        logic [31:0] rd, st;
        int n;
        reset = 1'b1;
        bus.cmd_register = 0; bus.address_register = 0;
        bus.data_in_register = 0; bus.start_cc_pointer_register = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("reset_status", bus.status_register, ST_IDLE);
        check_eq("reset_data_o", bus.data_o_register, 32'h0);

        do_write(4, 32'h0002_0001);
        do_read(4, rd); check_eq("read4", rd, 32'h0000_0001);
        do_read(5, rd); check_eq("read5", rd, 32'h0000_0002);

        for (int k = 0; k < 8; k++) do_write(200 + 2 * k, $urandom);
        do_write(1023, $urandom);
        for (int a = 200; a < 216; a++) begin
            exp_q.push_back({16'h0, mem_m[a]});
            do_read(a, rd);
            check_eq("rand_mem", rd, exp_q.pop_front());
        end
        do_read(1023, rd); check_eq("wrap_hi", rd, {16'h0, mem_m[1023]});
        do_read(0, rd);    check_eq("wrap_lo", rd, {16'h0, mem_m[0]});

        set_abc_prog();
        load_prog(8);
        str_b[0] = "a"; str_b[1] = "b"; str_b[2] = "c"; str_b[3] = "b";
        load_str(8, 4);
        run_case("abcb", 8, ST_ACC);
        str_b[0] = "a"; str_b[1] = "b"; str_b[2] = "d";
        load_str(8, 3);
        run_case("abd", 8, ST_REJ);
        repeat (10) @(negedge clk);
        check_eq("rej_hold", bus.status_register, ST_REJ);
        do_reset();
        check_eq("rej_reset", bus.status_register, ST_IDLE);

        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) str_b[i] = 8'h61 + 8'($urandom_range(0, 3));
            if (it % 3 == 0 && n > 0) str_b[0] = "a";
            load_str(64, n);
            run_case("rand_abc", 64, model_abc(n));
        end

        clear_prog();
        load_prog(2);
        load_str(64, 0);
        drive_cmd(3, 0, 0, 64);
        check_eq("lat_fetch", bus.status_register, ST_RUN);
        @(negedge clk);
        check_eq("lat_exec", bus.status_register, ST_RUN);
        @(negedge clk);
        check_eq("lat_accept", bus.status_register, ST_ACC);
        prog[0] = 16'h0161;
        load_prog(2);
        run_case("match_empty", 64, ST_REJ);

        for (int it = 0; it < 10; it++) begin
            clear_prog();
            pat_n = $urandom_range(1, 4);
            for (int i = 0; i < pat_n; i++) begin
                pat[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h61 + 8'($urandom_range(0, 1));
                prog[i] = (pat[i] == 8'h00) ? 16'h0400 : {8'h01, pat[i]};
            end
            prog[pat_n] = 16'h0000;
            load_prog(pat_n + 1);
            n = (it % 2 == 0) ? pat_n : $urandom_range(0, 5);
            for (int i = 0; i < n; i++) str_b[i] = 8'h61 + 8'($urandom_range(0, 1));
            load_str(64, n);
            run_case("rand_lin", 64, model_lin(n));
        end

        clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0311;
        load_prog(18);
        load_str(64, 0);
        run_case("stack_16", 64, ST_ACC);
        prog[16] = 16'h0311; prog[17] = 16'h0000;
        load_prog(18);
        run_case("stack_17", 64, ST_REJ);

        do_write(300, 32'hBEEF_1234);
        do_read(300, rd); check_eq("pre_run_read", rd, 32'h0000_1234);
        clear_prog();
        prog[0] = 16'h0200;
        load_prog(2);
        drive_cmd(3, 0, 0, 64);
        repeat (20) @(negedge clk);
        check_eq("loop_running", bus.status_register, ST_RUN);
        drive_cmd(1, 300, 32'h5555_AAAA, 0);
        drive_cmd(2, 301, 0, 0);
        check_eq("run_read_ignored", bus.data_o_register, 32'h0000_1234);
        do_reset();
        check_eq("midrun_reset", bus.status_register, ST_IDLE);
        do_read(300, rd); check_eq("run_write_ign0", rd, 32'h0000_1234);
        do_read(301, rd); check_eq("run_write_ign1", rd, 32'h0000_BEEF);

`ifdef REGEX_TIMEOUT_EN
        begin
            int cyc = 0;
            drive_cmd(3, 0, 0, 64);
            while (cyc < MAX_CYCLES + 100 && bus.status_register == ST_RUN) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("timeout_result", bus.status_register, ST_REJ);
            check_eq("timeout_late", 32'(cyc >= MAX_CYCLES - 8), 32'd1);
            check_eq("timeout_bound", 32'(cyc <= MAX_CYCLES + 8), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
